// File: rtl/renkon_pkg.sv
// Shared pooling constants, sideband payload and max-tree geometry helpers.
package renkon_pkg;

  localparam int unsigned DWIDTH    = 16;
  localparam int unsigned POOL_KMAX = 9;
  localparam logic [DWIDTH-1:0] MINVAL = {1'b1, {(DWIDTH-1){1'b0}}};

  // Per-beat control travelling alongside the data pipeline
  typedef struct packed {
    logic valid;
    logic last;
    logic relu;
  } side_t;

  // Number of nodes at tree level k for n input lanes (level 0 = inputs)
  function automatic int unsigned lvl_width(input int unsigned n, input int unsigned k);
    return (n + (32'd1 << k) - 32'd1) >> k;
  endfunction

  // Offset of tree level k (k >= 1) in a flat node vector holding levels 1..L
  function automatic int unsigned node_off(input int unsigned n, input int unsigned k);
    int unsigned s;
    s = 0;
    for (int unsigned j = 1; j < k; j++) s += lvl_width(n, j);
    return s;
  endfunction

endpackage

// File: rtl/renkon_pool_maxn_if.sv
// Pooling stream bus: input beats (lanes, live-lane count, window end, relu)
// and the pooled result channel, both valid/ready handshaked.
//   slave  : the pooling block
//   master : the producer/consumer driving it
interface renkon_pool_maxn_if #(
  parameter int unsigned DWIDTH = renkon_pkg::DWIDTH,
  parameter int unsigned KMAX   = renkon_pkg::POOL_KMAX,
  parameter int unsigned CWIDTH = $clog2(KMAX + 1)
);
  logic                         in_valid;
  logic                         in_ready;
  logic [KMAX-1:0][DWIDTH-1:0]  in_pixel;
  logic [CWIDTH-1:0]            in_count;
  logic                         in_last;
  logic                         relu_en;
  logic                         out_valid;
  logic                         out_ready;
  logic [DWIDTH-1:0]            out_pmap;

  modport slave (
    input  in_valid, in_pixel, in_count, in_last, relu_en, out_ready,
    output in_ready, out_valid, out_pmap
  );

  modport master (
    output in_valid, in_pixel, in_count, in_last, relu_en, out_ready,
    input  in_ready, out_valid, out_pmap
  );
endinterface

// File: rtl/renkon_max_tree.sv
// Registered signed pairwise max tree, KMAX lanes -> 1, one register level
// per tree level, all levels advancing on a shared enable.
//   clk, xrst : clock, async active-high reset
//   en        : advance all levels
//   din       : KMAX signed lanes
//   dout      : signed maximum, $clog2(KMAX) cycles after din
module renkon_max_tree
  import renkon_pkg::*;
#(
  parameter int unsigned DWIDTH = renkon_pkg::DWIDTH,
  parameter int unsigned KMAX   = renkon_pkg::POOL_KMAX
) (
  input  logic                        clk,
  input  logic                        xrst,
  input  logic                        en,
  input  logic [KMAX-1:0][DWIDTH-1:0] din,
  output logic [DWIDTH-1:0]           dout
);

  localparam int unsigned L     = $clog2(KMAX);
  localparam int unsigned NODES = node_off(KMAX, L + 1);

  function automatic logic [DWIDTH-1:0] smax(input logic [DWIDTH-1:0] a,
                                             input logic [DWIDTH-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // All levels packed into one flat node vector; level k starts at node_off(KMAX, k)
  logic [NODES-1:0][DWIDTH-1:0] node_q;
  logic [NODES-1:0][DWIDTH-1:0] node_d;

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int unsigned OFF = node_off(KMAX, k);
    localparam int unsigned SRC = node_off(KMAX, k - 1);
    localparam int unsigned WI  = lvl_width(KMAX, k - 1);
    localparam int unsigned WO  = lvl_width(KMAX, k);
    for (genvar i = 0; i < WO; i++) begin : g_node
      // Odd trailing node of a level is passed straight through
      if (k == 1) begin : g_in
        if (2 * i + 1 < WI) begin : g_cmp
          assign node_d[OFF+i] = smax(din[2*i], din[2*i+1]);
        end else begin : g_pass
          assign node_d[OFF+i] = din[2*i];
        end
      end else begin : g_mid
        if (2 * i + 1 < WI) begin : g_cmp
          assign node_d[OFF+i] = smax(node_q[SRC+2*i], node_q[SRC+2*i+1]);
        end else begin : g_pass
          assign node_d[OFF+i] = node_q[SRC+2*i];
        end
      end
    end
  end

  // Level registers
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst)    node_q <= '0;
    else if (en) node_q <= node_d;
  end

  assign dout = node_q[NODES-1];

endmodule

// File: rtl/renkon_pool_maxn.sv
// Streaming max pooling: masks dead lanes, reduces each beat through a
// registered max tree, accumulates the max across a window's beats and
// emits one (optionally ReLU-clamped) result per window.
//   clk, xrst : clock, async active-high reset
//   bus       : slave side of the pooling stream bus (in_* beats, out_* result)
module renkon_pool_maxn
  import renkon_pkg::*;
#(
  parameter int unsigned DWIDTH = renkon_pkg::DWIDTH,
  parameter int unsigned KMAX   = renkon_pkg::POOL_KMAX,
  parameter int unsigned CWIDTH = $clog2(KMAX + 1)
) (
  input  logic                     clk,
  input  logic                     xrst,
  renkon_pool_maxn_if.slave        bus
);

  localparam int unsigned L = $clog2(KMAX);
  localparam logic [DWIDTH-1:0] MIN_V = {1'b1, {(DWIDTH-1){1'b0}}};

  function automatic logic [DWIDTH-1:0] smax(input logic [DWIDTH-1:0] a,
                                             input logic [DWIDTH-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  logic                        stall;
  logic                        en;
  logic [CWIDTH-1:0]           cnt_eff;
  logic [KMAX-1:0][DWIDTH-1:0] masked;
  logic [KMAX-1:0][DWIDTH-1:0] s0_pix;
  side_t                       s0_side;
  side_t [L-1:0]               side_pipe;
  side_t                       tail;
  logic [DWIDTH-1:0]           tree_max;
  logic [DWIDTH-1:0]           acc;
  logic [DWIDTH-1:0]           win_max;
  logic [DWIDTH-1:0]           res_val;

  // Whole pipeline freezes while a result waits for the consumer
  assign stall        = bus.out_valid && !bus.out_ready;
  assign en           = !stall;
  assign bus.in_ready = !stall;

  // Dead lanes become MINVAL so they never win; counts above KMAX saturate
  always_comb begin
    cnt_eff = (bus.in_count > CWIDTH'(KMAX)) ? CWIDTH'(KMAX) : bus.in_count;
    masked  = '0;
    for (int unsigned i = 0; i < KMAX; i++)
      masked[i] = (i < 32'(cnt_eff)) ? bus.in_pixel[i] : MIN_V;
  end

  // Stage 0 and the sideband shift register that shadows the tree levels
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      s0_pix    <= '0;
      s0_side   <= '0;
      side_pipe <= '0;
    end else if (en) begin
      s0_pix       <= masked;
      s0_side      <= side_t'{bus.in_valid, bus.in_last, bus.relu_en};
      side_pipe[0] <= s0_side;
      for (int unsigned j = 1; j < L; j++) side_pipe[j] <= side_pipe[j-1];
    end
  end

  renkon_max_tree #(
    .DWIDTH (DWIDTH),
    .KMAX   (KMAX)
  ) u_tree (
    .clk  (clk),
    .xrst (xrst),
    .en   (en),
    .din  (s0_pix),
    .dout (tree_max)
  );

  assign tail = side_pipe[L-1];

  // Window result: running max folded with this beat, clamped at zero on relu
  always_comb begin
    win_max = smax(acc, tree_max);
    res_val = (tail.relu && win_max[DWIDTH-1]) ? '0 : win_max;
  end

  // Accumulator / output stage; acc restarts as soon as a window closes
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      acc          <= MIN_V;
      bus.out_valid <= 1'b0;
      bus.out_pmap  <= '0;
    end else if (en) begin
      bus.out_valid <= tail.valid && tail.last;
      if (tail.valid) begin
        if (tail.last) begin
          bus.out_pmap <= res_val;
          acc          <= MIN_V;
        end else begin
          acc <= win_max;
        end
      end
    end
  end

endmodule

// File: tb/tb_renkon_pool_maxn.sv
// Directed bench for renkon_pool_maxn: table of single-beat windows plus
// hand sequences for multi-beat windows, bubbles, back-pressure and reset.
module tb_renkon_pool_maxn;
  import renkon_pkg::*;

  localparam int unsigned KM = 9;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
  localparam int VMIN = -32768;
  localparam int VMAX = 32767;

  logic clk = 1'b0;
  logic xrst;
  always #5 clk = ~clk;

  renkon_pool_maxn_if #(.DWIDTH(DW), .KMAX(KM), .CWIDTH(CW)) bus ();

  renkon_pool_maxn #(.DWIDTH(DW), .KMAX(KM), .CWIDTH(CW)) dut (
    .clk  (clk),
    .xrst (xrst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int cyc;
  } res_t;
  res_t res_q[$];

  // Every completed result handshake, in order
  always @(negedge clk) begin
    if (!xrst && bus.out_valid && bus.out_ready)
      res_q.push_back('{int'($signed(bus.out_pmap)), cyc});
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [KM-1:0][DW-1:0] pk(input int a0, input int a1, input int a2,
                                               input int a3, input int a4, input int a5,
                                               input int a6, input int a7, input int a8);
    logic [KM-1:0][DW-1:0] r;
    int a[KM];
    a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    for (int j = 0; j < KM; j++) r[j] = DW'(a[j]);
    return r;
  endfunction

  task automatic send(input logic [KM-1:0][DW-1:0] pix, input int cnt, input bit last,
                      input bit relu, output int acc_cyc);
    bit got;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_pixel = pix;
    bus.in_count = CW'(cnt);
    bus.in_last  = last;
    bus.relu_en  = relu;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk);
      #1;
    end
    acc_cyc = cyc;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
  endtask

  task automatic wait_res(input int n, input string name);
    for (int t = 0; t < 60 && res_q.size() < n; t++) @(posedge clk);
    #1;
    if (res_q.size() < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d results expected %0d", name, res_q.size(), n);
    end
  endtask

  typedef struct {
    logic [KM-1:0][DW-1:0] pix;
    int cnt;
    bit relu;
    int exp;
  } vec_t;
  vec_t vecs[10];

  int ac;
  int sv[8];

  initial begin
    vecs[0] = '{pk(3, -7, 12, 0, 5, -1, 9, 2, 8), 9, 1'b0, 12};
    vecs[1] = '{pk(-5, -5, -5, -5, -5, -5, -5, -5, 100), 8, 1'b0, -5};
    vecs[2] = '{pk(-5, -5, -5, -5, -5, -5, -5, -5, 100), 8, 1'b1, 0};
    vecs[3] = '{pk(VMIN, VMAX, VMIN, VMAX, VMIN, VMIN, VMAX, VMIN, VMAX), 0, 1'b0, VMIN};
    vecs[4] = '{pk(VMIN, VMAX, VMIN, VMAX, VMIN, VMIN, VMAX, VMIN, VMAX), 9, 1'b0, VMAX};
    vecs[5] = '{pk(VMIN, VMAX, VMIN, VMAX, VMIN, VMIN, VMAX, VMIN, VMAX), 0, 1'b1, 0};
    vecs[6] = '{pk(-4, -9, -2, 50, 60, 70, 80, 90, 99), 3, 1'b0, -2};
    vecs[7] = '{pk(1, 2, 3, 4, 5, 6, 7, 8, 77), 15, 1'b0, 77};
    vecs[8] = '{pk(-1, -2, -3, -4, -5, -6, -7, -8, -9), 9, 1'b1, 0};
    vecs[9] = '{pk(-100, 500, 500, 500, 500, 500, 500, 500, 500), 1, 1'b0, -100};

    xrst          = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_pixel  = '0;
    bus.in_count  = '0;
    bus.in_last   = 1'b0;
    bus.relu_en   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_pmap", int'($signed(bus.out_pmap)), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    xrst = 1'b0;
    @(posedge clk);
    #1;

    // Single-beat windows: value, latency (5 edges = result in cycle n+6), single pulse
    for (int v = 0; v < 10; v++) begin
      res_q.delete();
      send(vecs[v].pix, vecs[v].cnt, 1'b1, vecs[v].relu, ac);
      bus.in_valid = 1'b0;
      wait_res(1, $sformatf("vec%0d", v));
      if (res_q.size() >= 1) begin
        check($sformatf("vec%0d_pmap", v), res_q[0].val, vecs[v].exp);
        check($sformatf("vec%0d_latency", v), res_q[0].cyc - ac, 5);
      end
      repeat (4) @(posedge clk);
      #1;
      check($sformatf("vec%0d_count", v), res_q.size(), 1);
    end

    // Three-beat window then a single-beat window: acc must clear between them
    res_q.delete();
    send(pk(4, 0, -1, 2, 3, 1, -8, -9, 4), 9, 1'b0, 1'b0, ac);
    send(pk(-5, 17, 3, 0, 0, 0, 0, 0, 16), 9, 1'b0, 1'b0, ac);
    send(pk(-2, -3, -4, -5, -6, -7, -8, -9, -10), 9, 1'b1, 1'b0, ac);
    send(pk(1, 0, -1, -2, -3, -4, -5, -6, -7), 9, 1'b1, 1'b0, ac);
    bus.in_valid = 1'b0;
    wait_res(2, "multi");
    repeat (6) @(posedge clk);
    #1;
    check("multi_count", res_q.size(), 2);
    if (res_q.size() >= 2) begin
      check("multi_win1", res_q[0].val, 17);
      check("multi_win2", res_q[1].val, 1);
    end

    // Bubbles inside a window leave acc untouched
    res_q.delete();
    send(pk(9, 1, 2, 3, 4, 5, 6, 7, 8), 9, 1'b0, 1'b0, ac);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(pk(-3, -4, -5, -6, -7, -8, -9, -10, -11), 9, 1'b1, 1'b0, ac);
    bus.in_valid = 1'b0;
    wait_res(1, "bubble");
    repeat (6) @(posedge clk);
    #1;
    check("bubble_count", res_q.size(), 1);
    if (res_q.size() >= 1) check("bubble_pmap", res_q[0].val, 9);

    // Eight back-to-back results with three cycles of back-pressure mid-stream
    res_q.delete();
    for (int i = 0; i < 8; i++) sv[i] = 13 * i - 40;
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [KM-1:0][DW-1:0] p;
          p = pk(-1000, -1000, -1000, -1000, -1000, -1000, -1000, -1000, -1000);
          p[i % KM] = DW'(sv[i]);
          send(p, 9, 1'b1, 1'b0, ac);
        end
        bus.in_valid = 1'b0;
      end
      begin
        repeat (7) @(posedge clk);
        #3;
        bus.out_ready = 1'b0;
        #1;
        check("stall0_out_valid", int'(bus.out_valid), 1);
        check("stall0_in_ready", int'(bus.in_ready), 0);
        for (int s = 1; s < 3; s++) begin
          @(posedge clk);
          #4;
          check($sformatf("stall%0d_in_ready", s), int'(bus.in_ready), 0);
        end
        @(posedge clk);
        #3;
        bus.out_ready = 1'b1;
        #1;
        check("unstall_in_ready", int'(bus.in_ready), 1);
      end
    join
    wait_res(8, "stream");
    repeat (6) @(posedge clk);
    #1;
    check("stream_count", res_q.size(), 8);
    for (int i = 0; i < 8; i++)
      if (res_q.size() > i) check($sformatf("stream_res%0d", i), res_q[i].val, sv[i]);

    // Reset in the middle of a window discards the partial result
    res_q.delete();
    send(pk(50, 1, 2, 3, 4, 5, 6, 7, 8), 9, 1'b0, 1'b0, ac);
    bus.in_valid = 1'b0;
    xrst = 1'b1;
    #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_out_pmap", int'($signed(bus.out_pmap)), 0);
    check("midrst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    xrst = 1'b0;
    @(posedge clk);
    #1;
    send(pk(7, -1, -2, -3, -4, -5, -6, -7, -8), 9, 1'b1, 1'b0, ac);
    bus.in_valid = 1'b0;
    wait_res(1, "postrst");
    repeat (6) @(posedge clk);
    #1;
    check("postrst_count", res_q.size(), 1);
    if (res_q.size() >= 1) check("postrst_pmap", res_q[0].val, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
